bar_update_scheduler: RTL and testbench

- Sequences per-frame refresh of bar heights consumed by bar_graph.
- Once per video frame, on the vertical-blanking pulse, walks all frequency bins and fetches each magnitude from the spectrum buffer over a req/ack handshake.
- Applies fall-off smoothing and peak-hold to each bin.
- Writes height and peak into the bar height RAM, only during blanking, so the render path never sees a half-updated frame.

---
 rtl/viz_pkg.sv | 23 ++
 rtl/bar_dynamics.sv | 58 +++++
 rtl/bar_update_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_bar_update_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viz_pkg.sv
// Shared constants and types for the spectrum bar display.
//   NUM_BARS    number of frequency bins / bars (power of two)
//   HEIGHT_W    bar height width in pixels
//   MAX_H       tallest drawable bar
//   bar_idx_t   bin / bar RAM address
//   sched_state_t  bar_update_scheduler FSM states
package viz_pkg;

    localparam int unsigned NUM_BARS = 16;
    localparam int unsigned HEIGHT_W = 9;
    localparam int unsigned MAX_H    = 479;
    localparam int unsigned IDX_W    = $clog2(NUM_BARS);

    typedef logic [IDX_W-1:0] bar_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CALC,
        WRITE
    } sched_state_t;

endpackage

// File: rtl/bar_dynamics.sv
// Combinational per-bar smoothing: instant rise, clamped fall-off, and peak-hold.
//   tgt        target height for this frame (already saturated to MAX_H)
//   cur_h      height drawn last frame
//   peak       peak marker drawn last frame
//   hold       frames left before the peak may start falling
//   decay_sel  fall rate exponent: height falls 1 << decay_sel pixels per frame
//   new_h      height for this frame
//   new_pk     peak marker for this frame
//   new_hold   updated hold counter
module bar_dynamics
    import viz_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned HOLD_W      = $clog2(HOLD_FRAMES + 1)
) (
    input  logic [HEIGHT_W-1:0] tgt,
    input  logic [HEIGHT_W-1:0] cur_h,
    input  logic [HEIGHT_W-1:0] peak,
    input  logic [HOLD_W-1:0]   hold,
    input  logic [1:0]          decay_sel,
    output logic [HEIGHT_W-1:0] new_h,
    output logic [HEIGHT_W-1:0] new_pk,
    output logic [HOLD_W-1:0]   new_hold
);

    // One extra bit so step + tgt cannot overflow.
    logic [HEIGHT_W:0] step;
    logic [HEIGHT_W:0] floor_h;
    logic [HEIGHT_W-1:0] pk_dec;

    always_comb begin
        step    = {{HEIGHT_W{1'b0}}, 1'b1} << decay_sel;
        floor_h = step + {1'b0, tgt};
        pk_dec  = peak - 1'b1;

        // cur_h - step is used only when it stays at or above tgt, so it never wraps.
        if (tgt >= cur_h) begin
            new_h = tgt;
        end else if ({1'b0, cur_h} >= floor_h) begin
            new_h = cur_h - step[HEIGHT_W-1:0];
        end else begin
            new_h = tgt;
        end

        // In the final branch peak > new_h >= 0, so peak - 1 cannot wrap.
        if (new_h >= peak) begin
            new_pk   = new_h;
            new_hold = HOLD_W'(HOLD_FRAMES);
        end else if (hold != '0) begin
            new_pk   = peak;
            new_hold = hold - 1'b1;
        end else begin
            new_pk   = (pk_dec > new_h) ? pk_dec : new_h;
            new_hold = '0;
        end
    end

endmodule

// File: rtl/bar_update_scheduler.sv
// Once per frame, on vblank_start, fetches every bin magnitude over a req/ack handshake,
// smooths it into a bar height plus peak marker, and writes both into the bar height RAM.
//   clk, reset     system clock, synchronous active-high reset
//   vblank_start   one-cycle pulse at the start of vertical blanking
//   freeze         skip frame passes while high (sampled at vblank_start)
//   decay_sel      fall rate exponent, sampled in CALC
//   mag_req/idx    magnitude fetch request and bin index, held until mag_ack
//   mag_ack/data   magnitude valid strobe and value
//   bar_we/waddr   bar RAM write strobe and address
//   bar_wdata      smoothed height, peak_wdata peak marker
//   busy           pass in progress
//   overrun        vblank_start seen while a pass was still running (same cycle)
module bar_update_scheduler
    import viz_pkg::*;
#(
    parameter int unsigned MAG_W       = 16,
    parameter int unsigned MAG_SHIFT   = 7,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vblank_start,
    input  logic                freeze,
    input  logic [1:0]          decay_sel,
    output logic                mag_req,
    output logic [IDX_W-1:0]    mag_idx,
    input  logic                mag_ack,
    input  logic [MAG_W-1:0]    mag_data,
    output logic                bar_we,
    output logic [IDX_W-1:0]    bar_waddr,
    output logic [HEIGHT_W-1:0] bar_wdata,
    output logic [HEIGHT_W-1:0] peak_wdata,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    sched_state_t        state_q, state_d;
    bar_idx_t            idx_q, idx_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic                mag_req_q, mag_req_d;
    logic                busy_q, busy_d;
    logic                bar_we_q, bar_we_d;
    bar_idx_t            bar_waddr_q, bar_waddr_d;
    logic [HEIGHT_W-1:0] bar_wdata_q, bar_wdata_d;
    logic [HEIGHT_W-1:0] peak_wdata_q, peak_wdata_d;

    logic [HEIGHT_W-1:0] cur_h_q [NUM_BARS];
    logic [HEIGHT_W-1:0] cur_h_d [NUM_BARS];
    logic [HEIGHT_W-1:0] peak_q  [NUM_BARS];
    logic [HEIGHT_W-1:0] peak_d  [NUM_BARS];
    logic [HOLD_W-1:0]   hold_q  [NUM_BARS];
    logic [HOLD_W-1:0]   hold_d  [NUM_BARS];

    logic [MAG_W-1:0]    mag_shifted;
    logic [HEIGHT_W-1:0] tgt;
    logic [HEIGHT_W-1:0] new_h;
    logic [HEIGHT_W-1:0] new_pk;
    logic [HOLD_W-1:0]   new_hold;

    // Saturate instead of truncating: a full-scale bin must draw MAX_H, not wrap.
    always_comb begin
        mag_shifted = mag_q >> MAG_SHIFT;
        if (mag_shifted > MAG_W'(MAX_H)) begin
            tgt = HEIGHT_W'(MAX_H);
        end else begin
            tgt = mag_shifted[HEIGHT_W-1:0];
        end
    end

    bar_dynamics #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .HOLD_W      (HOLD_W)
    ) u_bar_dynamics (
        .tgt       (tgt),
        .cur_h     (cur_h_q[idx_q]),
        .peak      (peak_q[idx_q]),
        .hold      (hold_q[idx_q]),
        .decay_sel (decay_sel),
        .new_h     (new_h),
        .new_pk    (new_pk),
        .new_hold  (new_hold)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mag_d        = mag_q;
        mag_req_d    = mag_req_q;
        busy_d       = busy_q;
        bar_we_d     = 1'b0;
        bar_waddr_d  = bar_waddr_q;
        bar_wdata_d  = bar_wdata_q;
        peak_wdata_d = peak_wdata_q;
        cur_h_d      = cur_h_q;
        peak_d       = peak_q;
        hold_d       = hold_q;

        unique case (state_q)
            IDLE: begin
                if (vblank_start && !freeze) begin
                    state_d   = REQ;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    mag_req_d = 1'b1;
                end
            end
            REQ: begin
                if (mag_ack) begin
                    mag_d     = mag_data;
                    mag_req_d = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                // Outputs and history are registered here so they are valid in WRITE.
                bar_we_d       = 1'b1;
                bar_waddr_d    = idx_q;
                bar_wdata_d    = new_h;
                peak_wdata_d   = new_pk;
                cur_h_d[idx_q] = new_h;
                peak_d[idx_q]  = new_pk;
                hold_d[idx_q]  = new_hold;
                state_d        = WRITE;
            end
            WRITE: begin
                if (idx_q == bar_idx_t'(NUM_BARS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    mag_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mag_q        <= '0;
            mag_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            bar_we_q     <= 1'b0;
            bar_waddr_q  <= '0;
            bar_wdata_q  <= '0;
            peak_wdata_q <= '0;
            for (int i = 0; i < NUM_BARS; i++) begin
                cur_h_q[i] <= '0;
                peak_q[i]  <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mag_q        <= mag_d;
            mag_req_q    <= mag_req_d;
            busy_q       <= busy_d;
            bar_we_q     <= bar_we_d;
            bar_waddr_q  <= bar_waddr_d;
            bar_wdata_q  <= bar_wdata_d;
            peak_wdata_q <= peak_wdata_d;
            cur_h_q      <= cur_h_d;
            peak_q       <= peak_d;
            hold_q       <= hold_d;
        end
    end

    assign mag_req    = mag_req_q;
    assign mag_idx    = idx_q;
    assign bar_we     = bar_we_q;
    assign bar_waddr  = bar_waddr_q;
    assign bar_wdata  = bar_wdata_q;
    assign peak_wdata = peak_wdata_q;
    assign busy       = busy_q;
    assign overrun    = vblank_start & busy_q;

endmodule

// File: tb/tb_bar_update_scheduler.sv
module tb_bar_update_scheduler;

    localparam int NB = 16;

    typedef int mag_arr_t [NB];

    typedef struct {
        int tgt;
        int cur;
        int pk;
        int hold;
        int dsel;
        int exp_h;
        int exp_pk;
        int exp_hold;
    } dyn_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       vblank_start;
    logic       freeze;
    logic [1:0] decay_sel;
    logic       mag_req;
    logic [3:0] mag_idx;
    logic       mag_ack;
    logic [15:0] mag_data;
    logic       bar_we;
    logic [3:0] bar_waddr;
    logic [8:0] bar_wdata;
    logic [8:0] peak_wdata;
    logic       busy;
    logic       overrun;

    logic [8:0] d_tgt, d_cur, d_pk, d_new_h, d_new_pk;
    logic [4:0] d_hold, d_new_hold;
    logic [1:0] d_dsel;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, req_cnt = 0, ovr_cnt = 0;
    int m_h [NB];
    int m_pk [NB];
    int m_hold [NB];
    int last_h, last_pk;

    always #10 clk = ~clk;

    bar_update_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .vblank_start (vblank_start),
        .freeze       (freeze),
        .decay_sel    (decay_sel),
        .mag_req      (mag_req),
        .mag_idx      (mag_idx),
        .mag_ack      (mag_ack),
        .mag_data     (mag_data),
        .bar_we       (bar_we),
        .bar_waddr    (bar_waddr),
        .bar_wdata    (bar_wdata),
        .peak_wdata   (peak_wdata),
        .busy         (busy),
        .overrun      (overrun)
    );

    bar_dynamics u_dyn (
        .tgt       (d_tgt),
        .cur_h     (d_cur),
        .peak      (d_pk),
        .hold      (d_hold),
        .decay_sel (d_dsel),
        .new_h     (d_new_h),
        .new_pk    (d_new_pk),
        .new_hold  (d_new_hold)
    );

    always @(negedge clk) begin
        if (bar_we)  wr_cnt  <= wr_cnt + 1;
        if (mag_req) req_cnt <= req_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_h[i] = 0;
            m_pk[i] = 0;
            m_hold[i] = 0;
        end
    endtask

    // Frame update for one bar, straight from the smoothing rules.
    task automatic model_step(input int b, input int mag, input int dsel,
                              output int h, output int pk);
        int tgt;
        int fallen;
        tgt = mag / 128;
        if (tgt > 479) tgt = 479;
        fallen = m_h[b] - (2 ** dsel);
        if (tgt >= m_h[b]) h = tgt;
        else h = (fallen > tgt) ? fallen : tgt;
        if (h >= m_pk[b]) begin
            pk = h;
            m_hold[b] = 30;
        end else if (m_hold[b] > 0) begin
            pk = m_pk[b];
            m_hold[b] = m_hold[b] - 1;
        end else begin
            pk = (m_pk[b] - 1 > h) ? m_pk[b] - 1 : h;
        end
        m_h[b] = h;
        m_pk[b] = pk;
    endtask

    function automatic mag_arr_t fill(input int v);
        mag_arr_t a;
        for (int i = 0; i < NB; i++) a[i] = v;
        return a;
    endfunction

    function automatic mag_arr_t rand_mags();
        mag_arr_t a;
        for (int i = 0; i < NB; i++) begin
            case ($urandom_range(3))
                0: a[i] = 0;
                1: a[i] = int'($urandom_range(2047));
                2: a[i] = int'($urandom_range(65535));
                default: a[i] = 65535;
            endcase
        end
        return a;
    endfunction

    // Runs one frame pass starting from a vblank pulse. Called just after a posedge (+#1).
    // ovr_at > 0 pulses vblank again on that cycle; ovr_last pulses it on the final write;
    // abort_idx >= 0 asserts reset while bin abort_idx is being requested.
    task automatic run_pass(input mag_arr_t mags, input int dsel, input int dly,
                            input int ovr_at, input bit ovr_last, input int abort_idx);
        int widx = 0;
        int wait_cnt = 0;
        int cyc = 0;
        int ovr0;
        int wr0;
        int req0;
        int h, pk;
        ovr0 = ovr_cnt;
        wr0 = wr_cnt;
        decay_sel = 2'(dsel);
        vblank_start = 1'b1;
        @(posedge clk); #1;
        vblank_start = 1'b0;
        forever begin
            cyc++;
            vblank_start = (cyc == ovr_at);
            if (widx == NB && !busy) break;
            if (cyc > 600) begin
                check("pass_timeout_writes", widx, NB);
                break;
            end
            if (mag_req && int'(mag_idx) == abort_idx) begin
                reset = 1'b1;
                mag_ack = 1'b0;
                @(posedge clk); #1;
                check("abort_mag_req", int'(mag_req), 0);
                check("abort_bar_we", int'(bar_we), 0);
                check("abort_busy", int'(busy), 0);
                reset = 1'b0;
                model_reset();
                return;
            end
            if (mag_req) begin
                if (wait_cnt >= dly) begin
                    mag_ack = 1'b1;
                    mag_data = 16'(mags[mag_idx]);
                    check("mag_idx", int'(mag_idx), widx);
                end else begin
                    mag_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                mag_ack = 1'b0;
                wait_cnt = 0;
            end
            if (bar_we) begin
                model_step(widx, mags[widx], dsel, h, pk);
                check("bar_waddr", int'(bar_waddr), widx);
                check("bar_wdata", int'(bar_wdata), h);
                check("peak_wdata", int'(peak_wdata), pk);
                last_h = int'(bar_wdata);
                last_pk = int'(peak_wdata);
                if (ovr_last && widx == NB - 1) vblank_start = 1'b1;
                widx++;
            end
            @(posedge clk); #1;
        end
        mag_ack = 1'b0;
        check("pass_writes", wr_cnt - wr0, NB);
        check("pass_overrun_cycles", ovr_cnt - ovr0, int'(ovr_at > 0) + int'(ovr_last));
        req0 = req_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("no_extra_pass", req_cnt - req0, 0);
    endtask

    dyn_vec_t dvec [8];

    initial begin
        reset = 1'b1;
        vblank_start = 1'b0;
        freeze = 1'b0;
        decay_sel = 2'd0;
        mag_ack = 1'b0;
        mag_data = '0;
        model_reset();

        dvec[0] = '{32, 0, 0, 0, 0, 32, 32, 30};
        dvec[1] = '{0, 32, 32, 30, 2, 28, 32, 29};
        dvec[2] = '{0, 2, 5, 0, 3, 0, 4, 0};
        dvec[3] = '{10, 12, 20, 0, 2, 10, 19, 0};
        dvec[4] = '{479, 100, 200, 3, 1, 479, 479, 30};
        dvec[5] = '{5, 5, 5, 7, 0, 5, 5, 30};
        dvec[6] = '{0, 0, 1, 0, 1, 0, 0, 0};
        dvec[7] = '{3, 9, 9, 0, 1, 7, 8, 0};
        foreach (dvec[i]) begin
            d_tgt = 9'(dvec[i].tgt);
            d_cur = 9'(dvec[i].cur);
            d_pk = 9'(dvec[i].pk);
            d_hold = 5'(dvec[i].hold);
            d_dsel = 2'(dvec[i].dsel);
            #1;
            check($sformatf("dyn%0d_h", i), int'(d_new_h), dvec[i].exp_h);
            check($sformatf("dyn%0d_pk", i), int'(d_new_pk), dvec[i].exp_pk);
            check($sformatf("dyn%0d_hold", i), int'(d_new_hold), dvec[i].exp_hold);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_mag_req", int'(mag_req), 0);
        check("rst_bar_we", int'(bar_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_mag_idx", int'(mag_idx), 0);
        check("rst_bar_wdata", int'(bar_wdata), 0);
        check("rst_peak_wdata", int'(peak_wdata), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Rise to 32, then decay with peak-hold over 40 silent frames.
        run_pass(fill(16'h1000), 0, 2, 0, 1'b0, -1);
        check("f1_h", last_h, 32);
        check("f1_pk", last_pk, 32);
        for (int f = 2; f <= 41; f++) begin
            run_pass(fill(0), 2, int'($urandom_range(3)), 0, 1'b0, -1);
            if (f == 2) begin
                check("f2_h", last_h, 28);
                check("f2_pk", last_pk, 32);
            end
            if (f == 31) check("f31_pk_held", last_pk, 32);
            if (f == 32) check("f32_pk_falls", last_pk, 31);
        end

        run_pass(fill(16'hFFFF), 0, 0, 0, 1'b0, -1);
        check("sat_h", last_h, 479);
        check("sat_pk", last_pk, 479);

        run_pass(rand_mags(), 1, 1, 10, 1'b0, -1);
        run_pass(rand_mags(), 3, 0, 0, 1'b1, -1);

        begin
            int r0, w0;
            r0 = req_cnt;
            w0 = wr_cnt;
            freeze = 1'b1;
            vblank_start = 1'b1;
            @(posedge clk); #1;
            vblank_start = 1'b0;
            repeat (60) @(posedge clk);
            #1;
            check("freeze_reqs", req_cnt - r0, 0);
            check("freeze_writes", wr_cnt - w0, 0);
            check("freeze_busy", int'(busy), 0);
            freeze = 1'b0;
        end
        run_pass(rand_mags(), 0, 2, 0, 1'b0, -1);

        run_pass(fill(16'hFFFF), 0, 1, 0, 1'b0, 5);
        run_pass(fill(16'h1000), 3, 2, 0, 1'b0, -1);
        check("post_reset_h", last_h, 32);
        check("post_reset_pk", last_pk, 32);

        for (int f = 0; f < 25; f++) begin
            run_pass(rand_mags(), int'($urandom_range(3)), int'($urandom_range(3)),
                     0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
